// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shared shift-add / restoring-divide datapath with pipeline stall.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC and resolve in FIX.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [4:0]      AlUop,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned   CW      = $clog2(XLEN);
  localparam logic [CW-1:0] LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            neg_a;
  logic            neg_b;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [CW-1:0]   cnt;

  logic            is_mop;
  logic            accept;
  logic            a_signed;
  logic            b_signed;
  logic            in_neg_a;
  logic            in_neg_b;
  logic            in_div0;
  logic            in_ovf;
  logic            early;
  logic [XLEN-1:0] in_mag_a;
  logic [XLEN-1:0] in_mag_b;

  // Request decode and operand preparation
  always_comb begin
    is_mop = start && (AlUop[4:3] == 2'b01);
    accept = is_mop && !flush && ((state == IDLE) || (state == DONE));
    if (AlUop[2]) begin
      a_signed = !AlUop[0];
      b_signed = !AlUop[0];
    end else begin
      a_signed = (AlUop[1:0] != 2'b11);
      b_signed = !AlUop[1];
    end
    in_neg_a = a_signed && DATA1[XLEN-1];
    in_neg_b = b_signed && DATA2[XLEN-1];
    in_mag_a = in_neg_a ? -DATA1 : DATA1;
    in_mag_b = in_neg_b ? -DATA2 : DATA2;
    in_div0  = AlUop[2] && (DATA2 == '0);
    in_ovf   = AlUop[2] && !AlUop[0] && (DATA1 == MIN_NEG) && (DATA2 == '1);
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early = in_div0 || in_ovf;
`else
  assign early = 1'b0;
`endif

  assign stall = busy || ((state == IDLE) && is_mop && !flush);

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rs;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;

  // One iteration of the shared datapath: {hi,lo} shifts right for multiply, left for divide
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
    div_rs   = {hi, lo[XLEN-1]};
    div_ge   = (div_rs >= {1'b0, mag_b});
    div_diff = div_rs[XLEN-1:0] - mag_b;
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_val;

  // Sign correction and half/quotient/remainder selection
  always_comb begin
    prod   = {hi, lo};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quo_s  = (neg_a ^ neg_b) ? -lo : lo;
    rem_s  = neg_a ? -hi : hi;
    if (op[2]) begin
      if (div0)      fix_val = op[1] ? (neg_a ? -mag_a : mag_a) : '1;
      else if (ovf)  fix_val = op[1] ? '0 : MIN_NEG;
      else           fix_val = op[1] ? rem_s : quo_s;
    end else begin
      fix_val = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              op    <= AlUop[2:0];
              neg_a <= in_neg_a;
              neg_b <= in_neg_b;
              div0  <= in_div0;
              ovf   <= in_ovf;
              mag_a <= in_mag_a;
              mag_b <= in_mag_b;
              hi    <= '0;
              lo    <= AlUop[2] ? in_mag_a : in_mag_b;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= early ? FIX : CALC;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          CALC: begin
            if (op[2]) begin
              hi <= div_ge ? div_diff : div_rs[XLEN-1:0];
              lo <= {lo[XLEN-2:0], div_ge};
            end else begin
              hi <= mul_sum[XLEN:1];
              lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
          FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
